// File: rtl/dm_arbiter_pkg.sv
// dm_arbiter_pkg
//   Shared codes for the data-memory port arbiter:
//   - DM_OP_* access-type codes understood by dm (passed through untouched)
//   - arbiter state encoding (ARB_S_CPU / ARB_S_DMA)
//   - response owner ids (ARB_ID_CPU / ARB_ID_DMA) as seen on rid
package dm_arbiter_pkg;

    // dm access types; sign/zero extension and byte lanes are handled inside dm
    localparam logic [2:0] DM_OP_WD = 3'd0;  // word
    localparam logic [2:0] DM_OP_BS = 3'd1;  // byte, sign-extended load
    localparam logic [2:0] DM_OP_BZ = 3'd2;  // byte, zero-extended load
    localparam logic [2:0] DM_OP_HS = 3'd3;  // half, sign-extended load
    localparam logic [2:0] DM_OP_HZ = 3'd4;  // half, zero-extended load
    localparam logic [2:0] DM_OP_SB = 3'd5;  // byte store
    localparam logic [2:0] DM_OP_SH = 3'd6;  // half store

    // Which requester wins a tie
    typedef enum logic {
        ARB_S_CPU = 1'b0,
        ARB_S_DMA = 1'b1
    } arb_state_e;

    // Owner of a load response
    localparam logic ARB_ID_CPU = 1'b0;
    localparam logic ARB_ID_DMA = 1'b1;

endpackage

// File: rtl/dm_arbiter.sv
// dm_arbiter
//   Shares the single data-memory port between the CPU MEM stage and a
//   DMA/debug requester. One access per cycle; CPU wins ties unless the DMA
//   side has been refused WAIT_MAX cycles in a row, in which case the next tie
//   goes to the DMA. dm controls are driven combinationally from the winner;
//   load data is registered and returned the following cycle.
//
// Ports
//   clk, rst                         clock, asynchronous active-high reset
//   cpu_req/we/op/addr/wdata         CPU access request (op = DM_OP_*)
//   cpu_gnt, cpu_stall               CPU access done this cycle / CPU must hold
//   dma_req/we/op/addr/wdata         DMA access request
//   dma_gnt                          DMA access done this cycle
//   rvalid, rid, rdata               load response (cycle after a load grant)
//   dm_w, dm_r, dm_op, dm_addr,
//   dm_wdata, dm_rdata               data-memory port (combinational read)
//   state_dbg                        current tie-break state (arb_state_e)
//
// Handshake: a requester raises req with we/op/addr/wdata and holds all of
// them stable until it sees gnt in the same cycle. gnt=1 means the access is
// performed at the closing posedge; a refused request is not remembered, the
// requester simply keeps asking.
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int WAIT_MAX = 4,
    parameter int CW       = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [2:0]  cpu_op,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [2:0]  dma_op,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_gnt,
    output logic        rvalid,
    output logic        rid,
    output logic [31:0] rdata,
    output logic        dm_w,
    output logic        dm_r,
    output logic [2:0]  dm_op,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    output logic        state_dbg
);

    localparam logic [CW:0] WAIT_LIM = WAIT_MAX[CW:0];

    arb_state_e    state;
    logic [CW-1:0] starve;
    logic [CW:0]   starve_inc;
    logic          dma_refused;
    logic          load_gnt;

    // Winner selection and dm port mux
    always_comb begin
        cpu_gnt = ~rst & cpu_req & (~dma_req | (state == ARB_S_CPU));
        dma_gnt = ~rst & dma_req & (~cpu_req | (state == ARB_S_DMA));
        cpu_stall = cpu_req & ~cpu_gnt;

        dm_op    = cpu_op;
        dm_addr  = cpu_addr;
        dm_wdata = cpu_wdata;
        dm_w     = cpu_gnt & cpu_we;
        dm_r     = cpu_gnt & ~cpu_we;
        if (dma_gnt) begin
            dm_op    = dma_op;
            dm_addr  = dma_addr;
            dm_wdata = dma_wdata;
            dm_w     = dma_we;
            dm_r     = ~dma_we;
        end

        dma_refused = dma_req & ~dma_gnt;
        // One bit wider so the compare against WAIT_MAX cannot wrap
        starve_inc  = {1'b0, starve} + {{CW{1'b0}}, 1'b1};
        load_gnt    = (cpu_gnt & ~cpu_we) | (dma_gnt & ~dma_we);
    end

    // Tie-break state and starvation counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ARB_S_CPU;
            starve <= '0;
        end else begin
            if (!dma_refused)
                starve <= '0;
            else if (starve != {CW{1'b1}})
                starve <= starve + 1'b1;

            case (state)
                ARB_S_CPU:
                    if (dma_refused && (starve_inc >= WAIT_LIM))
                        state <= ARB_S_DMA;
                // Priority is handed back right after the DMA is served or
                // gives up, so it never lingers.
                ARB_S_DMA:
                    if (dma_gnt || !dma_req)
                        state <= ARB_S_CPU;
                default:
                    state <= ARB_S_CPU;
            endcase
        end
    end

    // Load response register; rdata keeps its last value between responses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid <= 1'b0;
            rid    <= ARB_ID_CPU;
            rdata  <= '0;
        end else if (load_gnt) begin
            rvalid <= 1'b1;
            rid    <= dma_gnt ? ARB_ID_DMA : ARB_ID_CPU;
            rdata  <= dm_rdata;
        end else begin
            rvalid <= 1'b0;
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_dm_arbiter.sv
module tb_dm_arbiter;
    import dm_arbiter_pkg::*;

    logic        clk;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [2:0]  cpu_op;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        cpu_gnt, cpu_stall;
    logic        dma_req, dma_we;
    logic [2:0]  dma_op;
    logic [31:0] dma_addr, dma_wdata;
    logic        dma_gnt;
    logic        rvalid, rid;
    logic [31:0] rdata;
    logic        dm_w, dm_r;
    logic [2:0]  dm_op;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        state_dbg;

    int n_checks = 0;
    int n_errors = 0;
    logic [32:0] exp_q[$];  // {rid, rdata}

    logic [31:0] mem [0:63];

    dm_arbiter #(.WAIT_MAX(4), .CW(3)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_op(cpu_op),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_op(dma_op),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt),
        .rvalid(rvalid), .rid(rid), .rdata(rdata),
        .dm_w(dm_w), .dm_r(dm_r), .dm_op(dm_op),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
        .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- data memory stand-in ----------------
    assign dm_rdata = mem[dm_addr[7:2]];
    always @(posedge clk) if (dm_w) mem[dm_addr[7:2]] <= dm_wdata;

    // ---------------- check helpers ----------------
    task automatic chk1(input string name, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    // Inputs are already set; check this cycle's grant picture at negedge,
    // queue the expected load response, then advance to posedge+1.
    task automatic step(input logic ecg, input logic edg, input logic [31:0] erd, input logic push);
        @(negedge clk);
        chk1("cpu_gnt", cpu_gnt, ecg);
        chk1("dma_gnt", dma_gnt, edg);
        chk1("cpu_stall", cpu_stall, cpu_req & ~ecg);
        chk1("dm_w", dm_w, (ecg & cpu_we) | (edg & dma_we));
        chk1("dm_r", dm_r, (ecg & ~cpu_we) | (edg & ~dma_we));
        if (ecg | edg) begin
            chk32("dm_addr", dm_addr, edg ? dma_addr : cpu_addr);
            chk32("dm_op", {29'd0, dm_op}, {29'd0, edg ? dma_op : cpu_op});
        end
        if ((ecg & cpu_we) | (edg & dma_we))
            chk32("dm_wdata", dm_wdata, edg ? dma_wdata : cpu_wdata);
        if (push && ((ecg & ~cpu_we) | (edg & ~dma_we)))
            exp_q.push_back({edg, erd});
        @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!rst && rvalid) begin
            if (exp_q.size() == 0) begin
                chk1("rvalid_unexpected", rvalid, 1'b0);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                chk1("rid", rid, e[32]);
                chk32("rdata", rdata, e[31:0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[4]  = 32'hA5A5_0001;  // 0x10
        mem[12] = 32'h3333_0030;  // 0x30
        mem[16] = 32'h1111_0040;  // 0x40
        mem[17] = 32'h2222_0044;  // 0x44

        rst = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_op = DM_OP_WD; cpu_addr = 32'h10; cpu_wdata = 32'h0;
        dma_req = 1'b0; dma_we = 1'b0; dma_op = DM_OP_HZ; dma_addr = 32'h0; dma_wdata = 32'h0;

        // Reset: requests are ignored while rst is high
        @(posedge clk);
        #1;
        chk1("rst_cpu_gnt", cpu_gnt, 1'b0);
        chk1("rst_dma_gnt", dma_gnt, 1'b0);
        chk1("rst_dm_r", dm_r, 1'b0);
        chk1("rst_dm_w", dm_w, 1'b0);
        chk1("rst_rvalid", rvalid, 1'b0);
        chk1("rst_rid", rid, 1'b0);
        chk32("rst_rdata", rdata, 32'h0);
        chk1("rst_state", state_dbg, ARB_S_CPU);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // CPU-only load of 0x10
        step(1'b1, 1'b0, 32'hA5A5_0001, 1'b1);
        cpu_req = 1'b0;
        step(1'b0, 1'b0, 32'h0, 1'b1);

        // Tie, both loading continuously: C C C C D C C C C D
        cpu_req = 1'b1; cpu_addr = 32'h40;
        dma_req = 1'b1; dma_addr = 32'h44;
        for (int i = 0; i < 10; i++) begin
            if (i == 4 || i == 9) step(1'b0, 1'b1, 32'h2222_0044, 1'b1);
            else                  step(1'b1, 1'b0, 32'h1111_0040, 1'b1);
        end

        // Starve counter restarts when dma_req drops
        step(1'b1, 1'b0, 32'h1111_0040, 1'b1);
        step(1'b1, 1'b0, 32'h1111_0040, 1'b1);
        dma_req = 1'b0;
        step(1'b1, 1'b0, 32'h1111_0040, 1'b1);
        dma_req = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h1111_0040, 1'b1);
        chk1("starve_state_cpu", state_dbg, ARB_S_CPU);
        step(1'b1, 1'b0, 32'h1111_0040, 1'b1);
        chk1("starve_state_dma", state_dbg, ARB_S_DMA);
        step(1'b0, 1'b1, 32'h2222_0044, 1'b1);
        dma_req = 1'b0;
        step(1'b1, 1'b0, 32'h1111_0040, 1'b1);
        chk1("back_state_cpu", state_dbg, ARB_S_CPU);

        // DMA store then CPU load of the same word
        cpu_req = 1'b0;
        dma_req = 1'b1; dma_we = 1'b1; dma_op = DM_OP_WD; dma_addr = 32'h20; dma_wdata = 32'hDEAD_BEEF;
        step(1'b0, 1'b1, 32'h0, 1'b1);
        dma_req = 1'b0; dma_we = 1'b0; dma_op = DM_OP_HZ; dma_addr = 32'h44;
        cpu_req = 1'b1; cpu_op = DM_OP_BS; cpu_addr = 32'h20;
        step(1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1);
        cpu_req = 1'b0;
        step(1'b0, 1'b0, 32'h0, 1'b1);

        // Reset right after a load grant, with the DMA side holding priority
        cpu_req = 1'b1; cpu_op = DM_OP_WD; cpu_addr = 32'h30;
        dma_req = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h3333_0030, 1'b1);
        step(1'b1, 1'b0, 32'h3333_0030, 1'b0);  // this response is lost
        chk1("pre_rst_rvalid", rvalid, 1'b1);
        chk32("pre_rst_rdata", rdata, 32'h3333_0030);
        chk1("pre_rst_state", state_dbg, ARB_S_DMA);
        rst = 1'b1;
        #1;
        chk1("async_rvalid", rvalid, 1'b0);
        chk1("async_cpu_gnt", cpu_gnt, 1'b0);
        chk1("async_dma_gnt", dma_gnt, 1'b0);
        chk1("async_dm_w", dm_w, 1'b0);
        chk1("async_dm_r", dm_r, 1'b0);
        chk1("async_state", state_dbg, ARB_S_CPU);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        // Counter was cleared: DMA again waits the full four cycles
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h3333_0030, 1'b1);
        step(1'b0, 1'b1, 32'h2222_0044, 1'b1);

        // Idle: no access, rdata holds the last response
        cpu_req = 1'b0; dma_req = 1'b0;
        step(1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            chk1("idle_rvalid", rvalid, 1'b0);
            chk32("idle_rdata", rdata, 32'h2222_0044);
        end

        chk32("exp_q_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
